// File: rtl/accel_host_seq.sv
// Host-side job sequencer: loads input bytes into the accelerator, kicks it, waits for done,
// and buffers result bytes in a FIFO. Define ACCEL_SEQ_TIMEOUT_EN to enable the RUN timeout.
module accel_host_seq #(
  parameter int ADDR_W         = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] input_addr,
  output logic [7:0]        input_data,
  output logic              input_we,
  output logic              start,
  input  logic              done,
  input  logic              busy,
  input  logic [7:0]        output_data,
  input  logic              output_valid,
  output logic              m_valid,
  output logic [7:0]        m_data,
  input  logic              m_ready,
  output logic              seq_busy,
  output logic              job_done,
  output logic [2:0]        err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("accel_host_seq: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_RUN, S_FINISH} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, len_q, len_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] input_addr_q, input_addr_d;
  logic [7:0]        input_data_q, input_data_d;
  logic              input_we_q, input_we_d;
  logic              s_ready_q, s_ready_d;
  logic              start_q, start_d;
  logic              job_done_q, job_done_d;
  logic              seq_busy_q, seq_busy_d;
  logic [2:0]        err_q, err_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              m_valid_q, m_valid_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              pop, push, full, ovf, tmo;

`ifdef ACCEL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] run_cnt_q, run_cnt_d;

  always_comb begin
    run_cnt_d = '0;
    if (state_q == S_RUN) run_cnt_d = run_cnt_q + TW'(1);
  end
  assign tmo = (run_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) run_cnt_q <= '0;
    else     run_cnt_q <= run_cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // Result FIFO: a full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    pop      = m_valid_q && m_ready;
    full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
               (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    push     = output_valid && (!full || pop);
    ovf      = output_valid && full && !pop;
    wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(push);
    rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(pop);
    m_valid_d = (wr_ptr_d != rd_ptr_d);
    // The byte being written this cycle becomes the head when the FIFO is otherwise empty.
    if (push && (rd_ptr_d == wr_ptr_q)) m_data_d = output_data;
    else                                m_data_d = mem_q[rd_ptr_d[PTR_W-1:0]];
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    input_addr_d = input_addr_q;
    input_data_d = input_data_q;
    input_we_d   = 1'b0;
    err_d        = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (run_req) begin
          if (busy) begin
            err_d[2] = 1'b1;
          end else begin
            err_d   = '0;
            base_d  = load_base;
            len_d   = load_len;
            cnt_d   = '0;
            state_d = (load_len != '0) ? S_LOAD : S_KICK;
          end
        end
      end
      S_LOAD: begin
        if (s_valid && s_ready_q) begin
          input_addr_d = base_q + cnt_q;
          input_data_d = s_data;
          input_we_d   = 1'b1;
          cnt_d        = cnt_q + ADDR_W'(1);
          if (cnt_q == len_q - ADDR_W'(1)) state_d = S_KICK;
        end
      end
      S_KICK:   state_d = S_RUN;
      S_RUN: begin
        if (done) begin
          state_d = S_FINISH;
        end else if (tmo) begin
          err_d[0] = 1'b1;
          state_d  = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (ovf) err_d[1] = 1'b1;
    // Registered outputs are decoded from the next state so they line up with it.
    s_ready_d  = (state_d == S_LOAD);
    start_d    = (state_d == S_KICK);
    job_done_d = (state_d == S_FINISH);
    seq_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= output_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      input_addr_q <= '0;
      input_data_q <= '0;
      input_we_q   <= 1'b0;
      s_ready_q    <= 1'b0;
      start_q      <= 1'b0;
      job_done_q   <= 1'b0;
      seq_busy_q   <= 1'b0;
      err_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      input_addr_q <= input_addr_d;
      input_data_q <= input_data_d;
      input_we_q   <= input_we_d;
      s_ready_q    <= s_ready_d;
      start_q      <= start_d;
      job_done_q   <= job_done_d;
      seq_busy_q   <= seq_busy_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign input_addr = input_addr_q;
  assign input_data = input_data_q;
  assign input_we   = input_we_q;
  assign start      = start_q;
  assign job_done   = job_done_q;
  assign seq_busy   = seq_busy_q;
  assign err        = err_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;

endmodule
